// File: rtl/acc_result_wb_writer.sv
// Write-back DMA: buffers the accelerator result stream in a small FIFO and
// drains it to DRAM as Wishbone classic write bursts from a programmed base address.
module acc_result_wb_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int BURST_LEN  = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  cfg_start_i,
  input  logic [31:0]           cfg_base_adr_i,
  input  logic [LEN_WIDTH-1:0]  cfg_len_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic                  acc_data_valid_i,
  input  logic [DATA_WIDTH-1:0] acc_data_i,
  output logic                  acc_ready_o,
  output logic                  dram_wbs_cyc_o,
  output logic                  dram_wbs_stb_o,
  output logic                  dram_wbs_we_o,
  output logic [3:0]            dram_wbs_sel_o,
  output logic [31:0]           dram_wbs_adr_o,
  output logic [DATA_WIDTH-1:0] dram_wbs_dat_o,
  input  logic                  dram_wbs_ack_i,
  output logic                  dram_burst_en_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_BURST = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [31:0]           adr_q, adr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [LEN_WIDTH-1:0]  acc_q, acc_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  full_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  in_burst_s;
  logic [LEN_WIDTH-1:0]  beats_s;
  logic                  fill_ok_s;

  assign full_s     = (count_q == CW'(DEPTH));
  assign empty_s    = (count_q == {CW{1'b0}});
  assign in_burst_s = (state_q == S_BURST);
  assign push_s     = acc_data_valid_i && acc_ready_o;
  // The burst only starts once every beat is buffered, so a pop never meets an empty FIFO.
  assign pop_s      = in_burst_s && dram_wbs_ack_i && !empty_s;
  assign beats_s    = (rem_q < LEN_WIDTH'(BURST_LEN)) ? rem_q : LEN_WIDTH'(BURST_LEN);
  assign fill_ok_s  = (LEN_WIDTH'(count_q) >= beats_s);

  // State register and datapath registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q  <= S_IDLE;
      adr_q    <= 32'h0000_0000;
      rem_q    <= {LEN_WIDTH{1'b0}};
      acc_q    <= {LEN_WIDTH{1'b0}};
      beat_q   <= {BW{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      beat_q   <= beat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage, written on every accepted result word
  always_ff @(posedge wb_clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= acc_data_i;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_start_i) begin
          if (cfg_len_i == {LEN_WIDTH{1'b0}}) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        if (fill_ok_s) begin
          state_d = S_BURST;
        end else begin
          state_d = S_FILL;
        end
      end
      S_BURST: begin
        if (pop_s && (beat_q <= BW'(1))) begin
          if (rem_q <= LEN_WIDTH'(1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = S_BURST;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Address, remaining-word and beat counters
  always_comb begin
    adr_d  = adr_q;
    rem_d  = rem_q;
    acc_d  = acc_q;
    beat_d = beat_q;
    if ((state_q == S_IDLE) && cfg_start_i) begin
      adr_d = cfg_base_adr_i;
      rem_d = cfg_len_i;
      acc_d = cfg_len_i;
    end else begin
      if (pop_s) begin
        adr_d = adr_q + 32'd4;
        if (rem_q != {LEN_WIDTH{1'b0}}) begin
          rem_d = rem_q - LEN_WIDTH'(1);
        end else begin
          rem_d = rem_q;
        end
        if (beat_q != {BW{1'b0}}) begin
          beat_d = beat_q - BW'(1);
        end else begin
          beat_d = beat_q;
        end
      end else if ((state_q == S_FILL) && fill_ok_s) begin
        beat_d = BW'(beats_s);
      end else begin
        beat_d = beat_q;
      end
      if (push_s && (acc_q != {LEN_WIDTH{1'b0}})) begin
        acc_d = acc_q - LEN_WIDTH'(1);
      end else begin
        acc_d = acc_q;
      end
    end
  end

  // FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? {AW{1'b0}} : wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? {AW{1'b0}} : rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Outputs decoded from registered state; bus fields read zero outside a burst
  always_comb begin
    busy_o          = (state_q != S_IDLE);
    done_o          = (state_q == S_DONE);
    acc_ready_o     = (state_q != S_IDLE) && !full_s && (acc_q != {LEN_WIDTH{1'b0}});
    dram_wbs_cyc_o  = in_burst_s;
    dram_wbs_stb_o  = in_burst_s;
    dram_wbs_we_o   = in_burst_s;
    dram_burst_en_o = in_burst_s;
    if (in_burst_s) begin
      dram_wbs_sel_o = 4'hF;
      dram_wbs_adr_o = adr_q;
      dram_wbs_dat_o = mem_q[rd_ptr_q];
    end else begin
      dram_wbs_sel_o = 4'h0;
      dram_wbs_adr_o = 32'h0000_0000;
      dram_wbs_dat_o = {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_acc_result_wb_writer.sv
// Directed bench for acc_result_wb_writer: a cycle-stepped producer and Wishbone
// slave model feed the DUT while captured beats are compared with hand-derived values.
module tb_acc_result_wb_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic [31:0] cfg_base;
  logic [15:0] cfg_len;
  logic        busy, done;
  logic        acc_valid;
  logic [31:0] acc_data;
  logic        acc_ready;
  logic        cyc, stb, we, burst_en, ack;
  logic [3:0]  sel;
  logic [31:0] adr, dat;

  int errors = 0;
  int checks = 0;

  logic [31:0] cap_adr[$];
  logic [31:0] cap_dat[$];
  int          burst_sz[$];
  int          done_cnt, accepted, bad_bus, hs_err, full_seen;
  bit          timed_out;

  always #5 clk = ~clk;

  acc_result_wb_writer dut (
    .wb_clk_i         (clk),
    .wb_rst_i         (rst_n),
    .cfg_start_i      (cfg_start),
    .cfg_base_adr_i   (cfg_base),
    .cfg_len_i        (cfg_len),
    .busy_o           (busy),
    .done_o           (done),
    .acc_data_valid_i (acc_valid),
    .acc_data_i       (acc_data),
    .acc_ready_o      (acc_ready),
    .dram_wbs_cyc_o   (cyc),
    .dram_wbs_stb_o   (stb),
    .dram_wbs_we_o    (we),
    .dram_wbs_sel_o   (sel),
    .dram_wbs_adr_o   (adr),
    .dram_wbs_dat_o   (dat),
    .dram_wbs_ack_i   (ack),
    .dram_burst_en_o  (burst_en)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one transfer: producer offers len+2 words (1,2,3,...), slave acks after
  // wait_n idle strobe cycles (first_wait for the very first beat).
  task automatic run_xfer(input logic [31:0] base, input int len, input int wait_n,
                          input int first_wait, input int mid_start);
    int  idx, waited, cur_burst, cycles, occ, acc_left, after, thr;
    bit  cyc_prev, seen_done, exp_ready, push, pop;
    cap_adr.delete(); cap_dat.delete(); burst_sz.delete();
    done_cnt = 0; bad_bus = 0; hs_err = 0; full_seen = 0; timed_out = 0;
    idx = 0; waited = 0; cur_burst = 0; cycles = 0; occ = 0; acc_left = len; after = 0;
    cyc_prev = 1'b0; seen_done = 1'b0;
    cfg_base = base; cfg_len = 16'(len); cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    while (after < 3 && cycles < 600) begin
      acc_valid = (idx < len + 2);
      acc_data  = 32'(idx + 1);
      thr       = (cap_adr.size() == 0) ? first_wait : wait_n;
      ack       = stb && (waited >= thr);
      if (cycles == mid_start) begin
        cfg_start = 1'b1; cfg_base = 32'hDEAD_0000; cfg_len = 16'd7;
      end else begin
        cfg_start = 1'b0;
      end
      exp_ready = !seen_done && (occ < 4) && (acc_left != 0);
      if (acc_ready !== exp_ready || busy !== !seen_done) hs_err++;
      if (occ == 4 && acc_ready === 1'b0) full_seen++;
      if (cyc && !cyc_prev) cur_burst = 0;
      if (!cyc && cyc_prev) burst_sz.push_back(cur_burst);
      if (stb && ack) begin
        cap_adr.push_back(adr);
        cap_dat.push_back(dat);
        if (sel !== 4'hF || we !== 1'b1 || cyc !== 1'b1 || burst_en !== 1'b1) bad_bus++;
        cur_burst++;
      end
      if (done) done_cnt++;
      push     = acc_valid && acc_ready;
      pop      = stb && ack;
      cyc_prev = cyc;
      tick;
      if (push) begin idx++; occ++; acc_left--; end
      if (pop) begin occ--; waited = 0; end
      else if (stb) waited++;
      if (done_cnt > 0) begin seen_done = 1'b1; after++; end
      cycles++;
    end
    if (cyc_prev) burst_sz.push_back(cur_burst);
    ack = 1'b0; acc_valid = 1'b0; cfg_start = 1'b0;
    timed_out = (cycles >= 600);
    accepted  = idx;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({cyc, stb, we, burst_en, sel, adr, dat, busy, done, acc_ready} !== 76'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0",
        {cyc, stb, we, burst_en, sel, adr, dat, busy, done, acc_ready});
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_two_bursts;
    int bad;
    run_xfer(32'h3800_0000, 8, 1, 1, -1);
    checks++;
    if (cap_adr.size() !== 8) begin errors++; $display("FAIL t1_beats: got %0d want 8", cap_adr.size()); end
    bad = 0;
    for (int k = 0; k < cap_adr.size(); k++)
      if (cap_adr[k] !== 32'h3800_0000 + 32'(4 * k) || cap_dat[k] !== 32'(k + 1)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL t1_adr_dat: got %0d bad beats want 0", bad); end
    checks++;
    if (burst_sz.size() !== 2 || burst_sz[0] !== 4 || burst_sz[1] !== 4) begin
      errors++; $display("FAIL t1_bursts: got %0d bursts want 2x4", burst_sz.size());
    end
    checks++;
    if (done_cnt !== 1 || timed_out) begin errors++; $display("FAIL t1_done: got %0d pulses want 1", done_cnt); end
    checks++;
    if (bad_bus !== 0 || hs_err !== 0) begin
      errors++; $display("FAIL t1_bus_hs: got bus=%0d hs=%0d want 0/0", bad_bus, hs_err);
    end
  endtask

  task automatic test_partial_burst;
    int bad;
    run_xfer(32'h0000_2000, 6, 0, 0, -1);
    checks++;
    if (burst_sz.size() !== 2 || burst_sz[0] !== 4 || burst_sz[1] !== 2) begin
      errors++; $display("FAIL t2_bursts: got %0d bursts want 4 then 2", burst_sz.size());
    end
    checks++;
    if (cap_adr.size() !== 6 || cap_adr[4] !== 32'h0000_2010) begin
      errors++; $display("FAIL t2_second_adr: got %0d beats want 6 with beat4 at 2010", cap_adr.size());
    end
    bad = 0;
    for (int k = 0; k < cap_dat.size(); k++) if (cap_dat[k] !== 32'(k + 1)) bad++;
    checks++;
    if (bad !== 0 || accepted !== 6) begin
      errors++; $display("FAIL t2_data: got bad=%0d accepted=%0d want 0/6", bad, accepted);
    end
  endtask

  task automatic test_stall;
    int bad;
    run_xfer(32'h0001_0000, 8, 0, 10, -1);
    checks++;
    if (full_seen == 0 || hs_err !== 0) begin
      errors++; $display("FAIL t3_backpressure: got full_cycles=%0d hs=%0d want >0/0", full_seen, hs_err);
    end
    bad = 0;
    for (int k = 0; k < cap_dat.size(); k++) if (cap_dat[k] !== 32'(k + 1)) bad++;
    checks++;
    if (cap_dat.size() !== 8 || bad !== 0 || accepted !== 8) begin
      errors++; $display("FAIL t3_no_loss: got beats=%0d bad=%0d acc=%0d want 8/0/8",
                         cap_dat.size(), bad, accepted);
    end
  endtask

  task automatic test_zero_len;
    int dcnt, dcyc, ccnt;
    cfg_base = 32'h0000_4000; cfg_len = 16'd0; cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    dcnt = 0; dcyc = -1; ccnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) begin dcnt++; if (dcyc < 0) dcyc = i; end
      if (cyc) ccnt++;
      tick;
    end
    checks++;
    if (dcnt !== 1 || dcyc < 0 || dcyc > 1) begin
      errors++; $display("FAIL t4_zero_done: got pulses=%0d at %0d want 1 within 2 cycles", dcnt, dcyc);
    end
    checks++;
    if (ccnt !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL t4_zero_bus: got cyc_cycles=%0d busy=%b want 0/0", ccnt, busy);
    end
    run_xfer(32'h0000_0100, 4, 1, 1, 3);
    checks++;
    if (cap_adr.size() !== 4 || cap_adr[0] !== 32'h0000_0100 || cap_adr[3] !== 32'h0000_010C
        || accepted !== 4 || done_cnt !== 1) begin
      errors++; $display("FAIL t4_start_busy: got beats=%0d acc=%0d want 4/4 at 0x100", cap_adr.size(), accepted);
    end
  endtask

  task automatic test_addr_wrap;
    logic [31:0] exp_a [4];
    int bad;
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC;
    exp_a[2] = 32'h0000_0000; exp_a[3] = 32'h0000_0004;
    run_xfer(32'hFFFF_FFF8, 4, 1, 1, -1);
    bad = 0;
    for (int k = 0; k < 4; k++) if (k >= cap_adr.size() || cap_adr[k] !== exp_a[k]) bad++;
    checks++;
    if (bad !== 0 || cap_adr.size() !== 4) begin
      errors++; $display("FAIL t5_wrap: got %0d bad of %0d beats want 0 of 4", bad, cap_adr.size());
    end
  endtask

  task automatic test_reset_mid_burst;
    int idx, bad;
    cfg_base = 32'h0000_8000; cfg_len = 16'd8; cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0; idx = 0;
    for (int i = 0; i < 40 && !stb; i++) begin
      acc_valid = 1'b1; acc_data = 32'h0000_0A00 + 32'(idx);
      if (acc_ready) idx++;
      tick;
    end
    acc_valid = 1'b0;
    checks++;
    if (stb !== 1'b1) begin errors++; $display("FAIL t6_reach_burst: got stb=%b want 1", stb); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cyc, stb, we, burst_en, sel, adr, dat, busy, done, acc_ready} !== 76'd0) begin
      errors++; $display("FAIL t6_async_reset: got %h want 0",
        {cyc, stb, we, burst_en, sel, adr, dat, busy, done, acc_ready});
    end
    tick; tick;
    rst_n = 1'b1;
    tick;
    run_xfer(32'h0000_9000, 4, 1, 1, -1);
    bad = 0;
    for (int k = 0; k < cap_dat.size(); k++)
      if (cap_dat[k] !== 32'(k + 1) || cap_adr[k] !== 32'h0000_9000 + 32'(4 * k)) bad++;
    checks++;
    if (cap_dat.size() !== 4 || bad !== 0 || done_cnt !== 1) begin
      errors++; $display("FAIL t6_after_reset: got beats=%0d bad=%0d done=%0d want 4/0/1",
                         cap_dat.size(), bad, done_cnt);
    end
  endtask

  initial begin
    cfg_start = 1'b0; cfg_base = 32'h0; cfg_len = 16'h0;
    acc_valid = 1'b0; acc_data = 32'h0; ack = 1'b0;
    test_reset();
    test_two_bursts();
    test_partial_burst();
    test_stall();
    test_zero_len();
    test_addr_wrap();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
